// File: rtl/rom_loader.sv
// Program download sequencer: packs host bytes into 16-bit instructions,
// writes them from address 0 and holds the CPU in reset until done.
module rom_loader #(
  parameter int ADDR_W        = 15,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_start,
  input  logic              dl_valid,
  input  logic [7:0]        dl_byte,
  output logic              dl_ready,
  input  logic              dl_end,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              cpu_reset,
  output logic              loading,
  output logic [15:0]       word_count,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_HI,
    S_RECV_LO,
    S_WRITE,
    S_RELEASE
  } state_t;

  localparam int CNT_W = $clog2(RELEASE_DELAY + 1);
  localparam logic [CNT_W-1:0] DELAY = CNT_W'(RELEASE_DELAY);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        hi_q, hi_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_data_q, rom_data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              loading_q, loading_d;
  logic              dl_ready_q, dl_ready_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              take;

  assign take = dl_valid && dl_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    hi_d         = hi_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    loading_d    = loading_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (dl_start) begin
          state_d      = S_RECV_HI;
          loading_d    = 1'b1;
          ptr_d        = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      S_RECV_HI: begin
        if (dl_end) begin
          state_d = S_RELEASE;
          cnt_d   = DELAY;
        end else if (take) begin
          hi_d    = dl_byte;
          state_d = S_RECV_LO;
        end
      end
      S_RECV_LO: begin
        if (dl_end) begin
          state_d = S_RELEASE;
          cnt_d   = DELAY;
        end else if (take) begin
          state_d    = S_WRITE;
          rom_we_d   = !overflow_q;
          rom_addr_d = ptr_q;
          rom_data_d = {hi_q, dl_byte};
        end
      end
      S_WRITE: begin
        if (word_count_q != 16'hFFFF)
          word_count_d = word_count_q + 16'd1;
        // Pointer parks on the last address; later words are dropped.
        if (ptr_q == PTR_MAX)
          overflow_d = 1'b1;
        else
          ptr_d = ptr_q + ADDR_W'(1);
        if (dl_end) begin
          state_d = S_RELEASE;
          cnt_d   = DELAY;
        end else begin
          state_d = S_RECV_HI;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = S_IDLE;
          loading_d = 1'b0;
        end
      end
      default: begin
        state_d = S_RELEASE;
        cnt_d   = DELAY;
      end
    endcase
    cpu_reset_d = (state_d != S_IDLE);
    dl_ready_d  = (state_d == S_RECV_HI) || (state_d == S_RECV_LO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_RELEASE;
      cnt_q        <= DELAY;
      ptr_q        <= '0;
      hi_q         <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      loading_q    <= 1'b0;
      dl_ready_q   <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      hi_q         <= hi_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      cpu_reset_q  <= cpu_reset_d;
      loading_q    <= loading_d;
      dl_ready_q   <= dl_ready_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dl_ready   = dl_ready_q;
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign loading    = loading_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

endmodule
